// File: rtl/ifu_fetch.sv
// Instruction fetch stage: drives a request/acknowledge instruction memory,
// owns the fetch PC and the IF/ID pipeline register. A one-entry buffer holds
// a word that returns while decode is stalled. A pending-redirect register
// remembers a branch target when no instruction was delivered that cycle, so
// the delay-slot word is never lost or fetched twice.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iPC_en,
  input  logic        iREGD_en,
  input  logic        iRedirect,
  input  logic [31:0] iRedirect_pc,
  output logic        oIM_req,
  output logic [31:0] oIM_addr,
  input  logic        iIM_ack,
  input  logic [31:0] iIM_rdata,
  output logic [31:0] oinstrD,
  output logic [31:0] oPCD,
  output logic [31:0] oPC8D,
  output logic        oValidD
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FULL = 2'd2
  } fetchState_t;

  fetchState_t state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_r;
  logic        redirPend_r;
  logic [31:0] redirPc_r;
  logic        imReq_r;
  logic [31:0] instrD_r;
  logic [31:0] pcD_r;
  logic        validD_r;

  logic        advance_s;
  logic        redirNow_s;
  logic [31:0] redirTarget_s;
  logic [31:0] nextPc_s;
  logic        deliver_s;
  logic [31:0] deliverInstr_s;

  // Stall decode, redirect sampling and next-PC selection.
  always_comb begin
    advance_s     = iPC_en && iREGD_en;
    redirNow_s    = iRedirect && iPC_en;
    // Targets are word aligned; the low two bits are dropped.
    redirTarget_s = iRedirect_pc & ~32'h0000_0003;
    if (redirNow_s) begin
      nextPc_s = redirTarget_s;
    end else if (redirPend_r) begin
      nextPc_s = redirPc_r;
    end else begin
      nextPc_s = pc_r + 32'd4;
    end
  end

  // Decide whether an instruction enters IF/ID this cycle and from where.
  always_comb begin
    deliver_s      = 1'b0;
    deliverInstr_s = buf_r;
    case (state_r)
      F_REQ: begin
        deliver_s      = iIM_ack && advance_s;
        deliverInstr_s = iIM_rdata;
      end
      F_FULL: begin
        deliver_s      = advance_s;
        deliverInstr_s = buf_r;
      end
      default: begin
        deliver_s      = 1'b0;
        deliverInstr_s = buf_r;
      end
    endcase
  end

  // Fetch FSM, PC, buffer, pending redirect and IF/ID register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= F_IDLE;
      pc_r        <= RESET_PC;
      buf_r       <= 32'h0000_0000;
      redirPend_r <= 1'b0;
      redirPc_r   <= 32'h0000_0000;
      imReq_r     <= 1'b0;
      instrD_r    <= 32'h0000_0000;
      pcD_r       <= 32'h0000_0000;
      validD_r    <= 1'b0;
    end else begin
      // IF/ID: real instruction, bubble, or hold on stall.
      if (advance_s) begin
        if (deliver_s) begin
          instrD_r <= deliverInstr_s;
          pcD_r    <= pc_r;
          validD_r <= 1'b1;
        end else begin
          instrD_r <= 32'h0000_0000;
          validD_r <= 1'b0;
        end
      end

      // A delivery consumes next_pc; otherwise a sampled redirect must wait.
      if (deliver_s) begin
        redirPend_r <= 1'b0;
      end else if (redirNow_s) begin
        redirPend_r <= 1'b1;
        redirPc_r   <= redirTarget_s;
      end

      case (state_r)
        F_IDLE: begin
          state_r <= F_REQ;
          imReq_r <= 1'b1;
        end
        F_REQ: begin
          if (iIM_ack) begin
            if (advance_s) begin
              pc_r    <= nextPc_s;
              imReq_r <= 1'b1;
            end else begin
              // pc_r stays at the buffered word's address until delivery.
              buf_r   <= iIM_rdata;
              state_r <= F_FULL;
              imReq_r <= 1'b0;
            end
          end
        end
        F_FULL: begin
          if (advance_s) begin
            pc_r    <= nextPc_s;
            state_r <= F_REQ;
            imReq_r <= 1'b1;
          end
        end
        default: begin
          state_r <= F_IDLE;
          imReq_r <= 1'b0;
        end
      endcase
    end
  end

  assign oIM_req  = imReq_r;
  assign oIM_addr = pc_r;
  assign oinstrD  = instrD_r;
  assign oPCD     = pcD_r;
  assign oValidD  = validD_r;
  assign oPC8D    = pcD_r + 32'd8;

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: iPC_en  input  1  PC advance enable from hazard stall logic (0 = stall).
REQ-004 SHALL have port: iREGD_en  input  1  IF/ID register enable from hazard stall logic (0 = stall).
REQ-005 SHALL have port: iRedirect  input  1  D-stage branch/jump taken (beq taken, jal, jr).
REQ-006 SHALL have port: iRedirect_pc  input  32  D-stage target address.
REQ-007 SHALL have port: oIM_req  output  1  instruction memory read request.
REQ-008 SHALL have port: oIM_addr  output  32  instruction memory word address.
REQ-009 SHALL have port: iIM_ack  input  1  read complete, iIM_rdata valid this cycle.
REQ-010 SHALL have port: iIM_rdata  input  32  fetched instruction.
REQ-011 SHALL have port: oinstrD  output  32  IF/ID instruction (to decode and hazard unit).
REQ-012 SHALL have port: oPCD  output  32  IF/ID PC.
REQ-013 SHALL have port: oPC8D  output  32  oPCD + 8 (jal link value).
REQ-014 SHALL have port: oValidD  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 SHALL have parameter: RESET_PC, default 32'h0000_3000, first fetch address.

Function
REQ-016 SHALL define advance = iPC_en && iREGD_en; any other combination is a stall.
REQ-017 SHALL implement fetch FSM states F_IDLE, F_REQ, F_FULL.
REQ-018 F_IDLE SHALL drive oIM_req=0 and go to F_REQ on the first clock edge with reset high.
REQ-019 F_REQ SHALL drive oIM_req=1, oIM_addr=pc, both held stable until iIM_ack.
REQ-020 F_REQ with iIM_ack and advance: iIM_rdata/pc load IF/ID with oValidD=1, pc <= next_pc, remain F_REQ (new request next cycle).
REQ-021 F_REQ with iIM_ack and no advance: iIM_rdata/pc captured in a 1-entry buffer, go to F_FULL.
REQ-022 F_REQ without iIM_ack and advance: IF/ID loads bubble (oinstrD=0, oValidD=0, oPCD unchanged); pc unchanged.
REQ-023 F_FULL SHALL drive oIM_req=0; on advance, buffer loads IF/ID with oValidD=1, pc <= next_pc, go to F_REQ.
REQ-024 On stall (advance=0), IF/ID outputs SHALL hold; buffer and pc SHALL hold except per REQ-021.
REQ-025 next_pc SHALL be: iRedirect_pc if iRedirect && iPC_en this cycle; else redir_pc if redir_pend; else pc+4 (mod 2^32, wraps).
REQ-026 Redirect sampled (iRedirect && iPC_en) in a cycle where no instruction is delivered to IF/ID SHALL set redir_pend=1, redir_pc=iRedirect_pc.
REQ-027 redir_pend SHALL clear when next_pc is consumed (instruction delivered to IF/ID); delay-slot instruction at branch+4 is always delivered before target.
REQ-028 Redirect target bits [1:0] SHALL be forced to 00; pc[1:0] always 00.
REQ-029 oPC8D SHALL equal oPCD + 8 combinationally (32-bit wrap).
REQ-030 No instruction SHALL be dropped or duplicated across any stall/ack/redirect interleaving.

Reset
REQ-031 reset low SHALL immediately (asynchronously) set: FSM F_IDLE, pc=RESET_PC, oIM_req=0, oIM_addr=RESET_PC, oinstrD=0, oPCD=0, oValidD=0, buffer empty, redir_pend=0.
REQ-032 reset asserted mid-fetch SHALL abandon the request; a late iIM_ack during/after reset with FSM not in F_REQ SHALL be ignored.

Verification
REQ-033 Reset release, 1-cycle ack memory, advance=1 -> oIM_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; oPCD follows one cycle later, oValidD=1.
REQ-034 3-cycle ack latency, advance=1 -> two bubbles (oValidD=0, oinstrD=0) between each valid instruction, no skipped address.
REQ-035 ack at 0x3004 during 2-cycle stall -> F_FULL, oIM_req=0; after stall oinstrD=word@0x3004, then request 0x3008.
REQ-036 beq at 0x3000 in D, iRedirect_pc=0x3040, delay slot delivered same cycle -> fetch sequence 0x3004, 0x3040, 0x3044.
REQ-037 Same redirect with delay-slot fetch outstanding (ack 2 cycles later) -> redir_pend=1, 0x3004 delivered, next oIM_addr=0x3040, redir_pend cleared.
REQ-038 reset pulsed low mid-request with iIM_ack arriving the same cycle -> all outputs at reset values, restart at 0x3000, acked data discarded.
